uart_rx: RTL

//  - UART receiver; decodes the serial frames that the UART transmit path produces.
//  - Samples the line on a 1-cycle strobe at OVERSAMPLE x baud. The strobe comes from a pulse_generator instance at the next level up.
//  - Frame: 1 start bit (0), DATA_BITS data bits LSB first, optional parity bit, 1 stop bit (1).

---
 rtl/uart_pkg.sv | 17 +
 rtl/bit_synchronizer.sv | 28 ++
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   uart_rx_state_t  receiver FSM state encoding
//   UART_IDLE_LEVEL  line level while idle (mark), also the stop bit value
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous, active-high reset; both flops load RESET_VAL
//   d    in   asynchronous input
//   q    out  synchronized output (two clk cycles of latency)
module bit_synchronizer #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Frame = start (0), DATA_BITS data bits LSB first,
// optional even parity bit, one stop bit (1). The line is sampled only on
// cycles where sample_pulse is high; sample_pulse runs at OVERSAMPLE x baud.
//
// Build option: define UART_RX_PARITY_EN to expect and check an even parity
// bit after the data bits. Without it, frames carry no parity bit and
// parity_error is tied to 0.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   rx_in          in   serial line, asynchronous, idle high
//   sample_pulse   in   1-cycle strobe at OVERSAMPLE x baud
//   data_out       out  last good received word
//   data_valid     out  1-cycle pulse when data_out holds a new word
//   framing_error  out  1-cycle pulse when the stop bit sampled as 0
//   parity_error   out  1-cycle pulse on parity mismatch (parity build only)
//
// state  | meaning
// IDLE   | waiting for a start edge
// START  | counting to the middle of the start bit, rejecting glitches
// DATA   | sampling data bits at mid-bit
// PARITY | sampling the parity bit at mid-bit
// STOP   | sampling the stop bit at mid-bit
// BREAK  | line held low after a framing error; wait for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 sample_pulse,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 parity_error
);

    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS + 1);

    localparam logic [SCW-1:0] MID_START   = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT    = BCW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state, state_nxt;
    logic [SCW-1:0]       scnt, scnt_nxt;
    logic [BCW-1:0]       bcnt, bcnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 load_word;
    logic                 ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                 perr_flag, perr_nxt;
    logic                 perr_set;
`endif

    bit_synchronizer #(
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            perr_flag <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
            bcnt  <= bcnt_nxt;
            shreg <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            perr_flag <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        load_word = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_nxt  = perr_flag;
        perr_set  = 1'b0;
`endif
        if (sample_pulse) begin
            case (state)
                IDLE: begin
                    if (rx_s != UART_IDLE_LEVEL) begin
                        state_nxt = START;
                        scnt_nxt  = '0;
                    end
                end
                START: begin
                    if (scnt == MID_START) begin
                        scnt_nxt = '0;
                        bcnt_nxt = '0;
                        // a start bit that has gone high again by mid-bit was noise
                        state_nxt = (rx_s == UART_IDLE_LEVEL) ? IDLE : DATA;
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
                DATA: begin
                    if (scnt == LAST_SAMPLE) begin
                        scnt_nxt  = '0;
                        shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                        if (bcnt == LAST_BIT) begin
                            bcnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end else begin
                            bcnt_nxt = bcnt + 1'b1;
                        end
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (scnt == LAST_SAMPLE) begin
                        scnt_nxt  = '0;
                        perr_nxt  = (rx_s != (^shreg));
                        state_nxt = STOP;
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (scnt == LAST_SAMPLE) begin
                        scnt_nxt = '0;
                        if (rx_s == UART_IDLE_LEVEL) begin
                            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (perr_flag) perr_set  = 1'b1;
                            else           load_word = 1'b1;
`else
                            load_word = 1'b1;
`endif
                        end else begin
                            // framing error wins; parity result is dropped
                            ferr_set  = 1'b1;
                            state_nxt = BREAK;
                        end
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s == UART_IDLE_LEVEL) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out      <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= load_word;
            framing_error <= ferr_set;
            if (load_word) data_out <= shreg;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_error <= 1'b0;
        else     parity_error <= perr_set;
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule
